cpu_bus_unit: RTL and testbench
===============================

CPU_BUS_UNIT -- requirements
Module: cpu_bus_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits; a multiple of 8.
REQ-003 SHALL have parameter BEAT_W, default 3, width of the burst-length field.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, WAIT-state cycles before abort.
REQ-005 SHALL have: one clock, reset asynchronous active-low; i_cpu_clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have: i_rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have: i_req_valid  in  1  CPU request present.
REQ-008 SHALL have: o_req_ready  out  1  unit idle, request accepted this edge if valid.
REQ-009 SHALL have: i_req_we  in  1  1 = write, 0 = read.
REQ-010 SHALL have: i_req_addr  in  ADDR_W  start address.
REQ-011 SHALL have: i_req_wdata  in  DATA_W  write data, sampled per beat.
REQ-012 SHALL have: i_req_beats  in  BEAT_W  beat count; 0 treated as 1.
REQ-013 SHALL have: o_rsp_valid  out  1  one-cycle pulse per completed beat.
REQ-014 SHALL have: o_rsp_rdata  out  DATA_W  read data of last beat.
REQ-015 SHALL have: o_rsp_err  out  1  valid with o_rsp_valid; 1 = timeout abort.
REQ-016 SHALL have: o_bus_clk, o_bus_we  out  1  bus strobe / write enable; o_bus_addr  out  ADDR_W; o_bus_data  out  DATA_W; i_bus_data  in  DATA_W; i_bus_data_ready  in  1  slave completion.

Function
REQ-017 SHALL implement states IDLE, SETUP, WAIT; o_req_ready = 1 only in IDLE.
REQ-018 SHALL, in IDLE on i_req_valid, latch we/addr/beats, load o_bus_addr/o_bus_we/o_bus_data (wdata), enter SETUP.
REQ-019 SHALL, in SETUP, set o_bus_clk <= 1 and enter WAIT; i_bus_data_ready ignored in SETUP.
REQ-020 SHALL, in WAIT with i_bus_data_ready = 1: o_bus_clk <= 0, o_rsp_valid <= 1, o_rsp_err <= 0, o_rsp_rdata <= i_bus_data (reads only; unchanged on writes).
REQ-021 SHALL then, if beats remaining > 1: decrement, o_bus_addr += DATA_W/8 modulo 2^ADDR_W (wrap), o_bus_data <= current i_req_wdata, enter SETUP; else enter IDLE.
REQ-022 SHALL give minimum latency 3 clocks from accepting edge to o_rsp_valid; burst beats 2 clocks apart minimum.
REQ-023 SHALL hold o_bus_addr/o_bus_we/o_bus_data stable from SETUP through end of WAIT.
REQ-024 SHALL ignore i_req_valid when not IDLE; no queuing.
REQ-025 SHALL keep o_rsp_valid and o_rsp_err low in every cycle not specified above.

Reset
REQ-026 SHALL, on i_rst_n = 0, immediately force IDLE, o_bus_clk = 0, o_bus_we = 0, o_bus_addr = 0, o_bus_data = 0, o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0, beat and timeout counters = 0; o_req_ready = 1.
REQ-027 SHALL, on reset mid-burst, drop the strobe asynchronously and issue no response for the aborted beat.

Configuration
REQ-028 SHALL, with BUS_TIMEOUT_EN defined, count WAIT cycles; on reaching TIMEOUT_CYCLES without ready: o_bus_clk <= 0, o_rsp_valid <= 1, o_rsp_err <= 1, discard remaining beats, enter IDLE.
REQ-029 SHALL, if ready and timeout coincide, treat the beat as successful (ready wins).
REQ-030 SHALL, without BUS_TIMEOUT_EN, wait in WAIT indefinitely, tie o_rsp_err to 0, and include no timeout counter.

Verification
REQ-031 Single read: addr 0x0000_1000, ready on 1st WAIT cycle with data 0xDEADBEEF -> o_rsp_valid 3 clocks after accept, rdata 0xDEADBEEF, err 0.
REQ-032 Write burst beats=4 at 0x0000_0100 -> bus addresses 0x100, 0x104, 0x108, 0x10C with o_bus_we = 1, four o_rsp_valid pulses, then o_req_ready = 1.
REQ-033 Wrap: read burst beats=2 at 0xFFFF_FFFC -> second beat address 0x0000_0000.
REQ-034 Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): ready never asserted -> after 16 WAIT cycles o_rsp_valid = 1 with err = 1, strobe low, IDLE; repeat with ready on cycle 16 -> err = 0.
REQ-035 Reset asserted during WAIT of beat 2 of 3 -> o_bus_clk low in same cycle, no o_rsp_valid, o_req_ready = 1 after release.
REQ-036 i_req_valid held high during a busy burst -> exactly one request accepted; next accepted only after IDLE is re-entered.

Source files
------------

// File: rtl/cpu_bus_unit.sv
// rtl/cpu_bus_unit.sv - CPU-to-bus burst transfer unit (IDLE/SETUP/WAIT handshake).
// Optional WAIT-state timeout abort is built when BUS_TIMEOUT_EN is defined.
module cpu_bus_unit #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int BEAT_W         = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              i_cpu_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   input  logic [BEAT_W-1:0] i_req_beats,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_bus_clk,
   output logic              o_bus_we,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [DATA_W-1:0] o_bus_data,
   input  logic [DATA_W-1:0] i_bus_data,
   input  logic              i_bus_data_ready
);

   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_bus_clk;
   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_data;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic [BEAT_W-1:0] r_beats;
   logic              w_done;
   logic              w_last;
   logic              w_timeout;

   assign w_done = (r_state == WAIT) && i_bus_data_ready;
   assign w_last = (r_beats <= BEAT_W'(1));

`ifdef BUS_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMR_W-1:0] r_timer;
   logic             r_rsp_err;

   // Ready is checked first, so a beat completing on the final WAIT cycle is a success.
   assign w_timeout = (r_state == WAIT) && !i_bus_data_ready &&
                      (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_timer   <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         r_rsp_err <= w_timeout;
         if (r_state == SETUP)
            r_timer <= '0;
         else if ((r_state == WAIT) && !i_bus_data_ready && !w_timeout)
            r_timer <= r_timer + TMR_W'(1);
      end
   end

   assign o_rsp_err = r_rsp_err;
`else
   assign w_timeout = 1'b0;
   assign o_rsp_err = 1'b0;
`endif

   always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_req_valid) w_next = SETUP;
         SETUP:   w_next = WAIT;
         WAIT: begin
            if (w_done)
               w_next = w_last ? IDLE : SETUP;
            else if (w_timeout)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bus_clk   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_data  <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_beats     <= '0;
      end else begin
         r_rsp_valid <= w_done || w_timeout;
         case (r_state)
            IDLE: begin
               if (i_req_valid) begin
                  r_bus_we   <= i_req_we;
                  r_bus_addr <= i_req_addr;
                  r_bus_data <= i_req_wdata;
                  r_beats    <= (i_req_beats == '0) ? BEAT_W'(1) : i_req_beats;
               end
            end
            SETUP: r_bus_clk <= 1'b1;
            WAIT: begin
               if (w_done) begin
                  r_bus_clk <= 1'b0;
                  if (!r_bus_we)
                     r_rsp_rdata <= i_bus_data;
                  if (!w_last) begin
                     r_beats    <= r_beats - BEAT_W'(1);
                     r_bus_addr <= r_bus_addr + ADDR_STEP;
                     r_bus_data <= i_req_wdata;
                  end else begin
                     r_beats <= '0;
                  end
               end else if (w_timeout) begin
                  r_bus_clk <= 1'b0;
                  r_beats   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_req_ready = (r_state == IDLE);
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_bus_clk   = r_bus_clk;
   assign o_bus_we    = r_bus_we;
   assign o_bus_addr  = r_bus_addr;
   assign o_bus_data  = r_bus_data;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// tb/tb_cpu_bus_unit.sv - randomized cycle-timeline check of cpu_bus_unit against a transaction model.
module tb_cpu_bus_unit;

   localparam int TO   = 16;
   localparam int MAXC = 4096;
`ifdef BUS_TIMEOUT_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid, i_req_we, i_bus_data_ready;
   logic [31:0] i_req_addr, i_req_wdata, i_bus_data;
   logic [2:0]  i_req_beats;
   logic        o_req_ready, o_rsp_valid, o_rsp_err, o_bus_clk, o_bus_we;
   logic [31:0] o_rsp_rdata, o_bus_addr, o_bus_data;

   always #5 clk = ~clk;

   cpu_bus_unit #(.ADDR_W(32), .DATA_W(32), .BEAT_W(3), .TIMEOUT_CYCLES(TO)) dut (
      .i_cpu_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_beats(i_req_beats),
      .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
      .o_bus_clk(o_bus_clk), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
      .o_bus_data(o_bus_data), .i_bus_data(i_bus_data), .i_bus_data_ready(i_bus_data_ready)
   );

   // per-cycle stimulus and expected outputs
   bit          s_valid [MAXC];
   bit          s_we    [MAXC];
   bit          s_ready [MAXC];
   logic [31:0] s_addr  [MAXC];
   logic [31:0] s_wdata [MAXC];
   logic [31:0] s_bdata [MAXC];
   logic [2:0]  s_beats [MAXC];
   bit          e_rr    [MAXC];
   bit          e_bclk  [MAXC];
   bit          e_rv    [MAXC];
   bit          e_re    [MAXC];
   bit          e_bwe   [MAXC];
   logic [31:0] e_rd    [MAXC];
   logic [31:0] e_ba    [MAXC];
   logic [31:0] e_bd    [MAXC];

   logic [31:0] m_addr = '0, m_data = '0, m_rd = '0, dir_bd = '0;
   bit          m_we = 1'b0, pend_v = 1'b0, pend_e = 1'b0, dir_bd_en = 1'b0;
   int          nc = 0, n_cyc = 0, cur = 0;
   bit          running = 1'b0;
   int          checks = 0, errors = 0;

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input int c, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b expected=%b", nm, c, act, exp);
      end
   endtask

   task automatic rand_in(input int c);
      s_valid[c] = 1'($urandom_range(0, 1));
      s_we[c]    = 1'($urandom_range(0, 1));
      s_addr[c]  = $urandom;
      s_wdata[c] = $urandom;
      s_beats[c] = 3'($urandom_range(0, 7));
      s_ready[c] = 1'($urandom_range(0, 1));
      s_bdata[c] = $urandom;
   endtask

   task automatic fill(input int c, input bit rr, input bit bc);
      e_rr[c]   = rr;
      e_bclk[c] = bc;
      e_ba[c]   = m_addr;
      e_bd[c]   = m_data;
      e_bwe[c]  = m_we;
      e_rd[c]   = m_rd;
      e_rv[c]   = pend_v;
      e_re[c]   = pend_e;
      pend_v    = 1'b0;
      pend_e    = 1'b0;
   endtask

   function automatic int pick_k();
      int r;
      if (!TEN) return int'($urandom_range(1, 5));
      r = int'($urandom_range(0, 9));
      if (r < 6) return int'($urandom_range(1, 4));
      if (r < 8) return TO - int'($urandom_range(0, 1));
      return TO + 1;
   endfunction

   // One request: accept cycle, then per beat one SETUP cycle and k WAIT cycles (ready on the k-th).
   task automatic add_txn(input bit we, input logic [31:0] addr, input logic [2:0] beats,
                          input int kfix, input int gap);
      int n, k, nw;
      bit tout;
      for (int g = 0; g < gap; g++) begin
         rand_in(nc); s_valid[nc] = 1'b0; fill(nc, 1'b1, 1'b0); nc++;
      end
      rand_in(nc);
      s_valid[nc] = 1'b1; s_we[nc] = we; s_addr[nc] = addr; s_beats[nc] = beats;
      fill(nc, 1'b1, 1'b0);
      m_we = we; m_addr = addr; m_data = s_wdata[nc];
      nc++;
      n = (beats == 3'd0) ? 1 : int'(beats);
      for (int b = 0; b < n; b++) begin
         rand_in(nc); fill(nc, 1'b0, 1'b0); nc++;
         if (kfix > 0) k = kfix;
         else if (kfix < 0) k = TO + 5;
         else k = pick_k();
         tout = TEN && (k > TO);
         nw   = tout ? TO : k;
         for (int j = 1; j <= nw; j++) begin
            rand_in(nc);
            s_ready[nc] = (j == k);
            if (j == k && dir_bd_en) s_bdata[nc] = dir_bd;
            fill(nc, 1'b0, 1'b1);
            nc++;
         end
         pend_v = 1'b1;
         pend_e = tout;
         if (tout) break;
         if (!m_we) m_rd = s_bdata[nc-1];
         if (b < n - 1) begin
            m_addr = m_addr + 32'd4;
            m_data = s_wdata[nc-1];
         end
      end
   endtask

   task automatic drive(input int c);
      i_req_valid      = s_valid[c];
      i_req_we         = s_we[c];
      i_req_addr       = s_addr[c];
      i_req_wdata      = s_wdata[c];
      i_req_beats      = s_beats[c];
      i_bus_data_ready = s_ready[c];
      i_bus_data       = s_bdata[c];
   endtask

   always @(negedge clk) begin
      if (running) begin
         chk1("req_ready", cur, o_req_ready, e_rr[cur]);
         chk1("bus_clk", cur, o_bus_clk, e_bclk[cur]);
         chk1("rsp_valid", cur, o_rsp_valid, e_rv[cur]);
         chk1("rsp_err", cur, o_rsp_err, e_re[cur]);
         chk1("bus_we", cur, o_bus_we, e_bwe[cur]);
         chk("rsp_rdata", cur, o_rsp_rdata, e_rd[cur]);
         chk("bus_addr", cur, o_bus_addr, e_ba[cur]);
         chk("bus_data", cur, o_bus_data, e_bd[cur]);
         case (cur)
            2:  chk1("lit_t1_early", cur, o_rsp_valid, 1'b0);
            3: begin
               chk1("lit_t1_valid", cur, o_rsp_valid, 1'b1);
               chk("lit_t1_rdata", cur, o_rsp_rdata, 32'hDEAD_BEEF);
               chk1("lit_t1_err", cur, o_rsp_err, 1'b0);
            end
            5:  chk("lit_t2_addr0", cur, o_bus_addr, 32'h0000_0100);
            7:  chk("lit_t2_addr1", cur, o_bus_addr, 32'h0000_0104);
            9:  chk("lit_t2_addr2", cur, o_bus_addr, 32'h0000_0108);
            11: begin
               chk("lit_t2_addr3", cur, o_bus_addr, 32'h0000_010C);
               chk1("lit_t2_we", cur, o_bus_we, 1'b1);
            end
            12: begin
               chk1("lit_t2_last_rsp", cur, o_rsp_valid, 1'b1);
               chk1("lit_t2_ready", cur, o_req_ready, 1'b1);
            end
            14: chk("lit_t3_addr0", cur, o_bus_addr, 32'hFFFF_FFFC);
            16: chk("lit_t3_wrap", cur, o_bus_addr, 32'h0000_0000);
`ifdef BUS_TIMEOUT_EN
            35: begin
               chk1("lit_t4_valid", cur, o_rsp_valid, 1'b1);
               chk1("lit_t4_err", cur, o_rsp_err, 1'b1);
               chk1("lit_t4_strobe", cur, o_bus_clk, 1'b0);
               chk1("lit_t4_idle", cur, o_req_ready, 1'b1);
            end
            53: begin
               chk1("lit_t5_valid", cur, o_rsp_valid, 1'b1);
               chk1("lit_t5_err", cur, o_rsp_err, 1'b0);
            end
`endif
            default: ;
         endcase
      end
   end

   initial begin
      int          gap;
      logic [31:0] addr;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_req_ready", -1, o_req_ready, 1'b1);
      chk1("rst_bus_clk", -1, o_bus_clk, 1'b0);
      chk1("rst_rsp_valid", -1, o_rsp_valid, 1'b0);
      chk1("rst_rsp_err", -1, o_rsp_err, 1'b0);
      chk1("rst_bus_we", -1, o_bus_we, 1'b0);
      chk("rst_bus_addr", -1, o_bus_addr, 32'h0);
      chk("rst_bus_data", -1, o_bus_data, 32'h0);
      chk("rst_rsp_rdata", -1, o_rsp_rdata, 32'h0);

      dir_bd_en = 1'b1; dir_bd = 32'hDEAD_BEEF;
      add_txn(1'b0, 32'h0000_1000, 3'd1, 1, 0);
      dir_bd_en = 1'b0;
      add_txn(1'b1, 32'h0000_0100, 3'd4, 1, 0);
      add_txn(1'b0, 32'hFFFF_FFFC, 3'd2, 1, 0);
      if (TEN) begin
         add_txn(1'b0, 32'h0000_3000, 3'd1, -1, 0);
         add_txn(1'b0, 32'h0000_3004, 3'd1, TO, 0);
      end
      while (nc < 3000) begin
         gap  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
         addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         add_txn(1'($urandom_range(0, 1)), addr, 3'($urandom_range(0, 7)), 0, gap);
      end
      rand_in(nc); s_valid[nc] = 1'b0; fill(nc, 1'b1, 1'b0); nc++;
      n_cyc = nc;

      rst_n = 1'b1;
      drive(0);
      cur = 0;
      running = 1'b1;
      for (int c = 1; c < n_cyc; c++) begin
         @(posedge clk);
         #1;
         drive(c);
         cur = c;
      end
      @(posedge clk);
      #1;
      running = 1'b0;
      drive_idle();

      // reset during WAIT of beat 2 of a 3-beat read
      @(posedge clk); #1;
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h0000_2000; i_req_beats = 3'd3;
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      @(posedge clk); #1;
      i_bus_data_ready = 1'b1; i_bus_data = 32'h1111_2222;
      @(posedge clk); #1;
      i_bus_data_ready = 1'b0;
      chk1("rst2_beat1_rsp", -1, o_rsp_valid, 1'b1);
      @(posedge clk); #1;
      chk1("rst2_strobe_on", -1, o_bus_clk, 1'b1);
      chk("rst2_addr", -1, o_bus_addr, 32'h0000_2004);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("rst2_strobe_drop", -1, o_bus_clk, 1'b0);
      chk1("rst2_no_rsp", -1, o_rsp_valid, 1'b0);
      chk1("rst2_ready", -1, o_req_ready, 1'b1);
      chk("rst2_bus_addr", -1, o_bus_addr, 32'h0);
      chk("rst2_rdata", -1, o_rsp_rdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("rst2_post_rsp", i, o_rsp_valid, 1'b0);
         chk1("rst2_post_ready", i, o_req_ready, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   task automatic drive_idle();
      i_req_valid      = 1'b0;
      i_req_we         = 1'b0;
      i_req_addr       = '0;
      i_req_wdata      = '0;
      i_req_beats      = '0;
      i_bus_data_ready = 1'b0;
      i_bus_data       = '0;
   endtask

endmodule
